// File: rtl/conv_kxk_mc_calc.sv
// conv_kxk_mc_calc: pipelined KxK signed convolution MAC that accumulates one
// output pixel over a framed group of input channels (in_first .. in_last).
// Build option: define CONV_RELU_EN to clamp negative results to zero
// (applied to result only; the running accumulator is never clamped).
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     input beat handshake (in_ready = ~stall, combinational)
//   in_first, in_last     group framing flags travelling with the beat
//   data_win, weight_win  K*K taps, row-major, tap r*K+c at [(r*K+c)*W +: W]
//   bias                  group bias, used on the first beat of a group
//   result, out_valid     group result and its valid flag
//   out_ready             downstream accept
module conv_kxk_mc_calc #(
  parameter int unsigned K      = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WGT_W  = 8,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [K*K*DATA_W-1:0]     data_win,
  input  logic [K*K*WGT_W-1:0]      weight_win,
  input  logic [BIAS_W-1:0]         bias,
  output logic [ACC_W-1:0]          result,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned TAPS   = K * K;
  localparam int unsigned PROD_W = DATA_W + WGT_W;

  logic                     stall;

  logic signed [PROD_W-1:0] prod_c [TAPS];
  logic signed [PROD_W-1:0] s1_prod [TAPS];
  logic                     s1_valid, s1_first, s1_last;
  logic [BIAS_W-1:0]        s1_bias;

  logic signed [ACC_W-1:0]  sum_c;
  logic [ACC_W-1:0]         s2_sum;
  logic                     s2_valid, s2_first, s2_last;
  logic [BIAS_W-1:0]        s2_bias;

  logic [ACC_W-1:0]         acc;
  logic                     grp_open;
  logic [ACC_W-1:0]         base_c, new_c, res_c;

  // Whole pipeline freezes while a finished result waits for downstream.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Per-tap signed products.
  always_comb begin
    for (int i = 0; i < int'(TAPS); i++) begin
      prod_c[i] = PROD_W'($signed(data_win[i*DATA_W +: DATA_W])) *
                  PROD_W'($signed(weight_win[i*WGT_W +: WGT_W]));
    end
  end

  // Adder tree over the registered products, sign-extended to ACC_W.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(TAPS); i++) begin
      sum_c = sum_c + ACC_W'(s1_prod[i]);
    end
  end

  // A beat with no open group behaves as a first beat and loads the bias.
  always_comb begin
    base_c = (s2_first | ~grp_open) ? ACC_W'($signed(s2_bias)) : acc;
    new_c  = base_c + s2_sum;
`ifdef CONV_RELU_EN
    res_c  = new_c[ACC_W-1] ? '0 : new_c;
`else
    res_c  = new_c;
`endif
  end

  // S1 / S2 / S3 registers; everything holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(TAPS); i++) s1_prod[i] <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_bias   <= '0;
      s2_sum    <= '0;
      s2_valid  <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_bias   <= '0;
      acc       <= '0;
      grp_open  <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      s1_prod   <= prod_c;
      s1_valid  <= in_valid;
      s1_first  <= in_first;
      s1_last   <= in_last;
      s1_bias   <= bias;

      s2_sum    <= sum_c;
      s2_valid  <= s1_valid;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      s2_bias   <= s1_bias;

      // Clears on transfer unless a new result lands on the same edge.
      out_valid <= s2_valid & s2_last;
      if (s2_valid) begin
        acc <= new_c;
        if (s2_last) begin
          result   <= res_c;
          grp_open <= 1'b0;
        end else begin
          grp_open <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_kxk_mc_calc.sv
module tb_conv_kxk_mc_calc;

  localparam int unsigned K = 3;
  localparam int unsigned T = K * K;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_first, in_last;
  logic [T*8-1:0] data_win, weight_win;
  logic [15:0] bias;
  logic [31:0] result;
  logic        out_valid, out_ready;

  conv_kxk_mc_calc #(.K(K), .DATA_W(8), .WGT_W(8), .BIAS_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .data_win(data_win),
    .weight_win(weight_win), .bias(bias), .result(result),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_q[$];
  int obs_q[$];
  int m_acc = 0;
  bit m_open = 1'b0;
  int last_exp = 0;
  bit prev_stall = 1'b0;
  logic [31:0] held = '0;
  int dv[T];
  int wv[T];
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int f_out(input int x);
`ifdef CONV_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  // Reference model and per-cycle compare; handshakes seen at the negedge
  // are the ones that complete on the following rising edge.
  always @(negedge clk) begin
    int dot;
    if (rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      exp_q.delete();
      m_open = 1'b0;
      m_acc = 0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_result_hold", $signed(result), $signed(held));
      end
      prev_stall = out_valid && !out_ready;
      held = result;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else chk("result", $signed(result), exp_q.pop_front());
        obs_q.push_back(int'($signed(result)));
      end
      if (in_valid && in_ready) begin
        dot = 0;
        for (int i = 0; i < int'(T); i++)
          dot += int'($signed(data_win[i*8 +: 8])) * int'($signed(weight_win[i*8 +: 8]));
        if (in_first || !m_open) m_acc = int'($signed(bias)) + dot;
        else m_acc = m_acc + dot;
        if (in_last) begin
          last_exp = f_out(m_acc);
          exp_q.push_back(last_exp);
          m_open = 1'b0;
        end else begin
          m_open = 1'b1;
        end
      end
    end
  end

  // Random downstream backpressure, changed away from both sampling points.
  always @(posedge clk) begin
    if (rand_ready) begin
      #2 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive_beat(input bit f, input bit l, input int b);
    bit took;
    int guard;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    bias     = 16'(b);
    for (int i = 0; i < int'(T); i++) begin
      data_win[i*8 +: 8]   = 8'(dv[i]);
      weight_win[i*8 +: 8] = 8'(wv[i]);
    end
    guard = 0;
    while (1) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) break;
      guard++;
      if (guard > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_obs(input string name, input int n);
    int guard = 0;
    while (obs_q.size() < n && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk(name, obs_q.size(), n);
  endtask

  task automatic fill_seq(input int w);
    for (int i = 0; i < int'(T); i++) begin
      dv[i] = i + 1;
      wv[i] = w;
    end
  endtask

  task automatic fill_const(input int d, input int w);
    for (int i = 0; i < int'(T); i++) begin
      dv[i] = d;
      wv[i] = w;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    data_win = '0; weight_win = '0; bias = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Single beat 1..9 * 1 + 0 = 45, with exact latency and a one-cycle pulse.
    obs_q.delete();
    fill_seq(1);
    drive_beat(1, 1, 0);
    in_valid = 1'b0;
    chk("lat_edge0", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_edge1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_edge2", out_valid, 1);
    chk("lat_result", $signed(result), 45);
    @(posedge clk); #1;
    chk("pulse_one_cycle", out_valid, 0);
    chk("model_pin_45", last_exp, 45);
    chk("t1_value", obs_q[0], 45);

    // Negative single beat.
    obs_q.delete();
    fill_const(-1, 1);
    drive_beat(1, 1, 0);
    idle(1);
    wait_obs("t2_count", 1);
`ifdef CONV_RELU_EN
    chk("t2_value", obs_q[0], 0);
`else
    chk("t2_value", obs_q[0], -9);
`endif

    // Four-channel group, bias 100, weights 2 -> 280, single output.
    obs_q.delete();
    for (int c = 0; c < 4; c++) begin
      fill_const(c + 1, 2);
      drive_beat(c == 0, c == 3, 100);
    end
    idle(6);
    chk("t3_count", obs_q.size(), 1);
    chk("t3_value", obs_q[0], 280);

    // Backpressure: 45, 46, 47 with out_ready low for 5 cycles.
    obs_q.delete();
    out_ready = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join_none
    fill_seq(1);
    for (int b = 0; b < 3; b++) drive_beat(1, 1, b);
    idle(1);
    wait_obs("t4_count", 3);
    idle(4);
    chk("t4_count_final", obs_q.size(), 3);
    chk("t4_v0", obs_q[0], 45);
    chk("t4_v1", obs_q[1], 46);
    chk("t4_v2", obs_q[2], 47);

    // Reset mid-group, then a fresh single-beat group with bias 5 -> 50.
    obs_q.delete();
    fill_const(3, 3);
    drive_beat(1, 0, 1000);
    drive_beat(0, 0, 1000);
    in_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    fill_seq(1);
    drive_beat(1, 1, 5);
    idle(6);
    chk("t5_count", obs_q.size(), 1);
    chk("t5_value", obs_q[0], 50);

    // Extremes, then a beat without in_first while no group is open.
    obs_q.delete();
    fill_const(-128, -128);
    drive_beat(1, 1, 32767);
    fill_seq(1);
    drive_beat(0, 1, 10);
    idle(6);
    chk("t6_count", obs_q.size(), 2);
    chk("t6_extreme", obs_q[0], 180223);
    chk("t6_nofirst", obs_q[1], 55);

    // Randomised groups, gaps and backpressure against the model.
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < int'(T); i++) begin
        dv[i] = int'($signed(8'($urandom)));
        wv[i] = int'($signed(8'($urandom)));
      end
      drive_beat($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 int'($signed(16'($urandom))));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    idle(10);
    chk("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
